// File: rtl/blake2_host_seq.sv
// rtl/blake2_host_seq.sv - host-side job sequencer for the BLAKE2 byte interface
module blake2_host_seq #(
    parameter int CONF_BYTES  = 8,
    parameter int BLOCK_BYTES = 64,
    parameter int HASH_BYTES  = 32,
    parameter int TIMEOUT_W   = 16
) (
    input  logic       clk,
    input  logic       rst_async,
    input  logic       job_start_i,
    input  logic       abort_i,
    output logic       busy_o,
    output logic       error_o,
    input  logic       src_valid_i,
    input  logic [7:0] src_data_i,
    input  logic       src_last_i,
    output logic       src_ready_o,
    output logic       dut_valid_o,
    output logic [1:0] dut_cmd_o,
    output logic [7:0] dut_data_o,
    input  logic       dut_ready_i,
    input  logic       dut_hash_v_i,
    input  logic [7:0] dut_hash_i,
    output logic       res_valid_o,
    output logic [7:0] res_data_o,
    output logic       res_last_o,
    output logic       done_o
);
    localparam int IDX_W  = $clog2(BLOCK_BYTES);
    localparam int CONF_W = (CONF_BYTES > 1) ? $clog2(CONF_BYTES) : 1;
    localparam int HASH_W = (HASH_BYTES > 1) ? $clog2(HASH_BYTES) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BLOCK_BYTES - 1);
    localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONF_BYTES - 1);
    localparam logic [HASH_W-1:0] HASH_LAST = HASH_W'(HASH_BYTES - 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CONF = 3'd1;
    localparam logic [2:0] ST_FILL = 3'd2;
    localparam logic [2:0] ST_SEND = 3'd3;
    localparam logic [2:0] ST_WAIT = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    localparam logic [2:0] ST_FIRST = (CONF_BYTES == 0) ? ST_FILL : ST_CONF;

    logic [2:0]           state_q, state_d;
    logic [CONF_W-1:0]    conf_cnt_q, conf_cnt_d;
    logic [IDX_W-1:0]     fill_cnt_q, fill_cnt_d;
    logic [IDX_W-1:0]     send_cnt_q, send_cnt_d;
    logic [HASH_W-1:0]    hash_cnt_q, hash_cnt_d;
    logic [TIMEOUT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                 blk_last_q, blk_last_d;
    logic                 error_q, error_d;
    logic                 res_valid_q, res_valid_d;
    logic [7:0]           res_data_q, res_data_d;
    logic                 res_last_q, res_last_d;
    logic                 done_q, done_d;
    logic [7:0]           blk_buf_q [BLOCK_BYTES];
    logic [7:0]           blk_buf_d [BLOCK_BYTES];

    logic src_xfer, dut_xfer, hash_xfer;

    assign busy_o      = (state_q != ST_IDLE);
    assign error_o     = error_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_last_o  = res_last_q;
    assign done_o      = done_q;

    // Config bytes pass straight through; data bytes leave only from the block buffer.
    always_comb begin
        src_ready_o = 1'b0;
        dut_valid_o = 1'b0;
        dut_cmd_o   = 2'b00;
        dut_data_o  = 8'h00;
        case (state_q)
            ST_CONF: begin
                dut_valid_o = src_valid_i;
                dut_data_o  = src_data_i;
                src_ready_o = dut_ready_i;
            end
            ST_FILL: src_ready_o = 1'b1;
            ST_SEND: begin
                dut_valid_o = 1'b1;
                dut_data_o  = blk_buf_q[send_cnt_q];
                dut_cmd_o   = blk_last_q ? 2'b11 : 2'b01;
            end
            default: ;
        endcase
    end

    assign src_xfer  = src_valid_i & src_ready_o;
    assign dut_xfer  = dut_valid_o & dut_ready_i;
    assign hash_xfer = (state_q == ST_WAIT) & dut_hash_v_i;

    always_comb begin
        state_d     = state_q;
        conf_cnt_d  = conf_cnt_q;
        fill_cnt_d  = fill_cnt_q;
        send_cnt_d  = send_cnt_q;
        hash_cnt_d  = hash_cnt_q;
        stall_cnt_d = stall_cnt_q;
        blk_last_d  = blk_last_q;
        error_d     = error_q;
        res_valid_d = 1'b0;
        res_data_d  = 8'h00;
        res_last_d  = 1'b0;
        done_d      = 1'b0;
        blk_buf_d   = blk_buf_q;

        case (state_q)
            ST_IDLE: begin
                if (job_start_i) begin
                    state_d    = ST_FIRST;
                    error_d    = 1'b0;
                    conf_cnt_d = '0;
                    fill_cnt_d = '0;
                    send_cnt_d = '0;
                    hash_cnt_d = '0;
                end
            end
            ST_CONF: begin
                if (src_xfer) begin
                    conf_cnt_d = conf_cnt_q + 1'b1;
                    if (conf_cnt_q == CONF_LAST) begin
                        state_d    = ST_FILL;
                        fill_cnt_d = '0;
                    end
                end
            end
            ST_FILL: begin
                if (src_xfer) begin
                    // The final byte also zero-pads every slot above it in the same cycle.
                    for (int i = 0; i < BLOCK_BYTES; i++) begin
                        if (int'(fill_cnt_q) == i) begin
                            blk_buf_d[i] = src_data_i;
                        end else if (src_last_i && (int'(fill_cnt_q) < i)) begin
                            blk_buf_d[i] = 8'h00;
                        end
                    end
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    if (src_last_i) begin
                        blk_last_d = 1'b1;
                        state_d    = ST_SEND;
                        send_cnt_d = '0;
                    end else if (fill_cnt_q == IDX_LAST) begin
                        blk_last_d = 1'b0;
                        state_d    = ST_SEND;
                        send_cnt_d = '0;
                    end
                end
            end
            ST_SEND: begin
                if (dut_xfer) begin
                    send_cnt_d = send_cnt_q + 1'b1;
                    if (send_cnt_q == IDX_LAST) begin
                        if (blk_last_q) begin
                            state_d    = ST_WAIT;
                            hash_cnt_d = '0;
                        end else begin
                            state_d    = ST_FILL;
                            fill_cnt_d = '0;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (dut_hash_v_i) begin
                    res_valid_d = 1'b1;
                    res_data_d  = dut_hash_i;
                    hash_cnt_d  = hash_cnt_q + 1'b1;
                    if (hash_cnt_q == HASH_LAST) begin
                        res_last_d = 1'b1;
                        done_d     = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_ERR: ;
            default: state_d = ST_IDLE;
        endcase

        // Any forward progress restarts the stall window; reaching all-ones is fatal.
        if ((state_q == ST_IDLE) || (state_q == ST_ERR)) begin
            stall_cnt_d = '0;
        end else if (src_xfer || dut_xfer || hash_xfer) begin
            stall_cnt_d = '0;
        end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
            if (&stall_cnt_d) begin
                state_d = ST_ERR;
                error_d = 1'b1;
            end
        end

        if (abort_i) begin
            state_d     = ST_IDLE;
            conf_cnt_d  = '0;
            fill_cnt_d  = '0;
            send_cnt_d  = '0;
            hash_cnt_d  = '0;
            stall_cnt_d = '0;
            blk_last_d  = 1'b0;
            error_d     = error_q;
            res_valid_d = 1'b0;
            res_data_d  = 8'h00;
            res_last_d  = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q     <= ST_IDLE;
            conf_cnt_q  <= '0;
            fill_cnt_q  <= '0;
            send_cnt_q  <= '0;
            hash_cnt_q  <= '0;
            stall_cnt_q <= '0;
            blk_last_q  <= 1'b0;
            error_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
            res_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            conf_cnt_q  <= conf_cnt_d;
            fill_cnt_q  <= fill_cnt_d;
            send_cnt_q  <= send_cnt_d;
            hash_cnt_q  <= hash_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            blk_last_q  <= blk_last_d;
            error_q     <= error_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_last_q  <= res_last_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        blk_buf_q <= blk_buf_d;
    end
endmodule

// File: doc/blake2_host_seq.md
Name: blake2_host_seq

Overview:
- Host-side job sequencer for the BLAKE2 top-level byte interface (8-bit data, 2-bit command plus valid, ready, hash_v, 8-bit hash out) in the FPGA emulator.
- Takes one message job from a byte-stream requester, such as a UART bridge or a self-test ROM.
- Forwards the config bytes, buffers each data block so it can be tagged DATA or LAST, zero-pads the final block and streams it to the core.
- Collects the hash bytes and flags stalls with a timeout.

Parameters:
- CONF_BYTES, 8, number of leading stream bytes sent as config (cmd 2'b00).
- BLOCK_BYTES, 64, block size in bytes; a power of 2 ≥ 2.
- HASH_BYTES, 32, number of hash bytes collected per job.
- TIMEOUT_W, 16, width of the stall counter; timeout fires after 2^TIMEOUT_W-1 idle cycles.

Ports:
- clk  in  1  system clock.
- rst_async  in  1  reset, asynchronous, active-high.
- job_start_i  in  1  start pulse; sampled only in IDLE.
- abort_i  in  1  synchronous abort; forces IDLE.
- busy_o  out  1  high whenever state != IDLE.
- error_o  out  1  sticky timeout flag.
- src_valid_i  in  1  source byte valid.
- src_data_i  in  8  source byte.
- src_last_i  in  1  marks the final message byte; ignored during config.
- src_ready_o  out  1  source byte accepted when src_valid_i & src_ready_o.
- dut_valid_o  out  1  byte valid toward the core.
- dut_cmd_o  out  2  command: 00 CONF, 01 DATA, 11 LAST.
- dut_data_o  out  8  byte toward the core.
- dut_ready_i  in  1  core ready.
- dut_hash_v_i  in  1  hash byte valid.
- dut_hash_i  in  8  hash byte.
- res_valid_o  out  1  result byte valid; single cycle, no backpressure.
- res_data_o  out  8  result byte.
- res_last_o  out  1  high with the final hash byte.
- done_o  out  1  one-cycle pulse coincident with res_last_o.

Behaviour:
- Reset: state IDLE, all counters 0, buffer contents don't-care, every output 0.
- Handshakes:
  - A core transfer occurs on a clk edge where dut_valid_o & dut_ready_i.
  - A source transfer occurs on a clk edge where src_valid_i & src_ready_o.
- IDLE:
  - job_start_i → CONF, with conf_cnt=0 and error_o cleared.
  - With CONF_BYTES=0, go directly to FILL.
- CONF (combinational pass-through):
  - dut_valid_o=src_valid_i, dut_data_o=src_data_i, dut_cmd_o=00, src_ready_o=dut_ready_i.
  - Each transfer increments conf_cnt; at CONF_BYTES → FILL.
- FILL:
  - src_ready_o=1; dut_valid_o=0.
  - Each accepted byte is written to buf[fill_cnt], then fill_cnt+1.
  - Accepted byte with src_last_i=1: latch blk_last=1, zero buf[fill_cnt+1..BLOCK_BYTES-1], then → SEND.
  - fill_cnt reaching BLOCK_BYTES without last: blk_last=0, → SEND.
  - A message of exactly N*BLOCK_BYTES bytes sends N blocks with no padding block.
  - Messages have ≥1 byte; the first data byte is never skipped.
- SEND:
  - dut_valid_o=1, dut_data_o=buf[send_cnt] (registered), dut_cmd_o = blk_last ? 11 : 01; src_ready_o=0.
  - Each transfer does send_cnt+1.
  - After byte BLOCK_BYTES-1: go to WAIT_HASH if blk_last, else back to FILL with fill_cnt=0.
  - Every byte of a block, including padding, carries the same cmd.
- WAIT_HASH:
  - Each cycle with dut_hash_v_i=1: res_valid_o=1, res_data_o=dut_hash_i (1-cycle registered latency), hash_cnt+1.
  - On byte HASH_BYTES: res_last_o=1 and done_o=1 that cycle, → IDLE.
  - dut_hash_v_i outside WAIT_HASH is ignored.
- Timeout:
  - stall_cnt clears on any source transfer, core transfer or hash byte, and in IDLE.
  - It increments otherwise.
  - At all-ones: error_o=1, → ERR.
- ERR:
  - All valid/ready outputs 0; busy_o=1.
  - Leave only via abort_i or rst_async.
  - error_o stays set until the next accepted job_start_i.
- abort_i (any state): next state IDLE, counters 0, all outputs 0 next cycle, error_o preserved. abort_i has priority over job_start_i.
- rst_async mid-job: immediate return to reset values; a partial block is discarded.

Test Plan:
- CONF_BYTES=8, then a 3-byte message {AA,BB,CC}+last → 8 bytes cmd 00, then 64 bytes cmd 11: AA,BB,CC plus 61×00. Then 32 hash bytes with hash_v → 32 res_valid pulses, res_last/done on the 32nd, busy_o drops.
- 128-byte message, last on byte 127 → two blocks: 64×cmd 01 then 64×cmd 11, no third block.
- 65-byte message → block 1 cmd 01; block 2 cmd 11 with 1 data byte + 63×00.
- dut_ready_i toggled 1/0 every cycle in SEND → every byte is sent exactly once, in order, with data held stable while ready is low.
- TIMEOUT_W=4, ready held low in SEND → error_o rises after 15 cycles, ERR entered. Then abort_i → IDLE, error_o stays 1; next job_start_i clears it.
- rst_async asserted mid-FILL after 10 bytes → all outputs 0 immediately. A new job then starts cleanly with the config phase.
